muu_sequencer: RTL
==================

Name: muu_sequencer

Overview:
Iterative multiply/divide sequencer that owns the HI/LO register pair of the MIPS datapath. It accepts one MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU/MTHI/MTLO operation per handshake and runs a 32-step shift-add or restoring-divide loop. It raises busy so the core stalls the PC while an operation is in flight. The core reads HI/LO directly for MFHI/MFLO/MUL.

Parameters:
DATA_WIDTH, 32, operand and HI/LO width; the iteration count equals DATA_WIDTH.
OPC_WIDTH, 4, width of op_code.

Ports:
muu_clock  in  1  single clock; all state updates on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
op_valid  in  1  request strobe from decode.
op_ready  out  1  high only in IDLE; an op is accepted on an edge where op_valid && op_ready.
op_code  in  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU, 8 MTHI, 9 MTLO, 10-15 reserved.
operand_a  in  32  rs value; sampled at accept.
operand_b  in  32  rt value; sampled at accept.
abort  in  1  cancels an in-flight op (pipeline flush).
busy  out  1  high from the cycle after accept until done; drives the PC stall.
done  out  1  one-cycle pulse marking completion.
div_by_zero  out  1  pulses together with done when DIV/DIVU has divisor 0.
hi  out  32  HI register.
lo  out  32  LO register.

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE; hi=0, lo=0; busy=0, done=0, div_by_zero=0; op_ready=1 after reset_n deasserts. Reset mid-operation discards the operation.
- States: IDLE, MUL_ITER, DIV_ITER, FINAL, DONE.
- IDLE, op accepted:
  - Codes 0,1,4-7 -> MUL_ITER.
  - Codes 2,3 -> DIV_ITER.
  - Codes 8,9 write hi or lo with operand_a on the accept edge, then go to DONE.
  - Codes 10-15 are accepted and ignored: stay in IDLE, no done pulse.
- Signed ops (MULT, DIV, MADD, MSUB): operand magnitudes and the result signs are latched at accept. The loop runs unsigned.
- MUL_ITER: 32 cycles, one multiplier bit per cycle. A 64-bit product accumulates in internal registers, then go to FINAL.
- DIV_ITER: 32 cycles, one restoring step per cycle, then go to FINAL.
- Divisor = 0: DIV_ITER is skipped and the sequencer goes straight to FINAL. hi and lo are left unchanged; div_by_zero pulses with done.
- FINAL (1 cycle), HI/LO updated on its exiting edge:
  - MULT/MULTU: {hi,lo} = product, negated if the signs differ.
  - MADD/MADDU: {hi,lo} = {hi,lo} + product, modulo 2^64.
  - MSUB/MSUBU: {hi,lo} = {hi,lo} - product, modulo 2^64.
  - DIV: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
  - DIV 0x80000000 / 0xffffffff: lo = 0x80000000, hi = 0.
- DONE (1 cycle): done=1; the next state is IDLE. op_ready is 0 in DONE, so back-to-back ops are spaced by 1 idle-ready cycle.
- Latency, accept edge to done high:
  - Multiply/divide: 34 cycles (32 iterations + FINAL + DONE entry).
  - Divide by zero: 2 cycles.
  - MTHI/MTLO: 1 cycle.
- busy = (state != IDLE) && (state != DONE).
- op_valid while not ready is ignored; the requester holds it until accepted.
- abort:
  - In MUL_ITER, DIV_ITER or FINAL: the next state is IDLE, hi and lo are unchanged, no done pulse.
  - In IDLE: no op is accepted that cycle.
  - In DONE: no effect.
- hi and lo are stable at all times except the FINAL exit edge and the MTHI/MTLO accept edge.

Optional Feature:
MUU_FAST_MULT_EN:
- Defined: multiply-class ops skip MUL_ITER. The product is computed combinationally at accept and goes straight to FINAL, so multiply latency is 2 cycles. Division is unchanged.
- Undefined: the 32-cycle iterative multiply described above.

Test Plan:
- MULT a=0xfffffffe, b=0x0000000e -> done at cycle 34; hi=0xffffffff, lo=0xffffffe4; busy high for cycles 1-32 plus FINAL.
- After that, MADD a=0xffffffe4, b=0xffffffff (product +28) -> hi=0x00000000, lo=0x00000000 (wrap). Then MSUBU a=0xfffffffe, b=0 -> hi/lo unchanged, done pulses.
- DIV a=0, b=0xfffffffe -> lo=0, hi=0. DIV a=7, b=0 -> done at cycle 2, div_by_zero=1, hi/lo unchanged. DIV a=0xfffffff9 (-7), b=2 -> lo=0xfffffffd, hi=0xffffffff.
- DIV a=0x80000000, b=0xffffffff -> lo=0x80000000, hi=0. DIVU a=0xffffffff, b=0x10 -> lo=0x0fffffff, hi=0xf.
- abort at cycle 10 of a MULTU -> IDLE next cycle, no done, hi/lo keep their prior values. reset_n low at cycle 20 of a DIV -> hi=lo=0 immediately, op_ready=1 once reset_n returns high.
- MTHI 0x1234 then MTLO 0x5678 back-to-back (op_valid held) -> each done 1 cycle after its accept; second accept 2 cycles after the first; hi=0x1234, lo=0x5678.

Source files
------------

// File: rtl/muu_sequencer_if.sv
// Request/response bundle between decode and the multiply/divide sequencer, plus the HI/LO read path.
interface muu_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OPC_WIDTH  = 4
);
  logic                  op_valid;
  logic                  op_ready;
  logic [OPC_WIDTH-1:0]  op_code;
  logic [DATA_WIDTH-1:0] operand_a;
  logic [DATA_WIDTH-1:0] operand_b;
  logic                  abort;
  logic                  busy;
  logic                  done;
  logic                  div_by_zero;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (
    output op_valid, op_code, operand_a, operand_b, abort,
    input  op_ready, busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  op_valid, op_code, operand_a, operand_b, abort,
    output op_ready, busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muu_sequencer.sv
// Iterative MIPS mul/div sequencer owning HI/LO: 34-cycle mul/div, 2-cycle div-by-zero, 1-cycle MTHI/MTLO;
// accepts only in IDLE (op_ready). Define MUU_FAST_MULT_EN for single-shot multiplies (2-cycle latency).
module muu_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int OPC_WIDTH  = 4
) (
  input logic            muu_clock,
  input logic            reset_n,
  muu_sequencer_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MUL   = 3'd1;
  localparam logic [2:0] S_DIV   = 3'd2;
  localparam logic [2:0] S_FINAL = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [OPC_WIDTH-1:0] OP_MULT  = 'd0;
  localparam logic [OPC_WIDTH-1:0] OP_MULTU = 'd1;
  localparam logic [OPC_WIDTH-1:0] OP_DIV   = 'd2;
  localparam logic [OPC_WIDTH-1:0] OP_DIVU  = 'd3;
  localparam logic [OPC_WIDTH-1:0] OP_MADD  = 'd4;
  localparam logic [OPC_WIDTH-1:0] OP_MADDU = 'd5;
  localparam logic [OPC_WIDTH-1:0] OP_MSUB  = 'd6;
  localparam logic [OPC_WIDTH-1:0] OP_MSUBU = 'd7;
  localparam logic [OPC_WIDTH-1:0] OP_MTHI  = 'd8;
  localparam logic [OPC_WIDTH-1:0] OP_MTLO  = 'd9;

  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [OPC_WIDTH-1:0] op;
  logic                 neg_q, neg_r, dbz;
  logic [2*W-1:0]       acc, mcand;
  logic [W-1:0]         opb;
  logic [W-1:0]         hi_q, lo_q;

  logic                 accept, is_signed, is_mul, is_div, a_neg, b_neg;
  logic [W-1:0]         mag_a, mag_b;
  logic [W:0]           div_shift, div_trial;
  logic [2*W-1:0]       prod_s, final_res;

  assign accept = bus.op_valid && (state == S_IDLE) && !bus.abort;

  always_comb begin
    is_signed = 1'b0;
    is_mul    = 1'b0;
    is_div    = 1'b0;
    case (bus.op_code)
      OP_MULT, OP_MADD, OP_MSUB:    begin is_mul = 1'b1; is_signed = 1'b1; end
      OP_MULTU, OP_MADDU, OP_MSUBU: is_mul = 1'b1;
      OP_DIV:                       begin is_div = 1'b1; is_signed = 1'b1; end
      OP_DIVU:                      is_div = 1'b1;
      default:                      ;
    endcase
  end

  // The loop works on magnitudes; signs are reapplied in FINAL.
  assign a_neg = is_signed && bus.operand_a[W-1];
  assign b_neg = is_signed && bus.operand_b[W-1];
  assign mag_a = a_neg ? -bus.operand_a : bus.operand_a;
  assign mag_b = b_neg ? -bus.operand_b : bus.operand_b;

  // Restoring step: remainder lives in acc[2W-1:W], dividend/quotient shifts through acc[W-1:0].
  assign div_shift = {acc[2*W-1:W], acc[W-1]};
  assign div_trial = div_shift - {1'b0, opb};

  assign prod_s = neg_q ? -acc : acc;

  always_comb begin
    final_res = {hi_q, lo_q};
    case (op)
      OP_MULT, OP_MULTU: final_res = prod_s;
      OP_MADD, OP_MADDU: final_res = {hi_q, lo_q} + prod_s;
      OP_MSUB, OP_MSUBU: final_res = {hi_q, lo_q} - prod_s;
      OP_DIV, OP_DIVU:   final_res = {neg_r ? -acc[2*W-1:W] : acc[2*W-1:W],
                                      neg_q ? -acc[W-1:0]   : acc[W-1:0]};
      default:           ;
    endcase
  end

  always_ff @(posedge muu_clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      op    <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dbz   <= 1'b0;
      acc   <= '0;
      mcand <= '0;
      opb   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op    <= bus.op_code;
          cnt   <= '0;
          dbz   <= 1'b0;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          opb   <= mag_b;
          mcand <= {{W{1'b0}}, mag_a};
          if (is_mul) begin
`ifdef MUU_FAST_MULT_EN
            acc   <= {{W{1'b0}}, mag_a} * {{W{1'b0}}, mag_b};
            state <= S_FINAL;
`else
            acc   <= '0;
            state <= S_MUL;
`endif
          end else if (is_div) begin
            acc <= {{W{1'b0}}, mag_a};
            if (mag_b == '0) begin
              dbz   <= 1'b1;
              state <= S_FINAL;
            end else begin
              state <= S_DIV;
            end
          end else if (bus.op_code == OP_MTHI) begin
            hi_q  <= bus.operand_a;
            state <= S_DONE;
          end else if (bus.op_code == OP_MTLO) begin
            lo_q  <= bus.operand_a;
            state <= S_DONE;
          end
        end
        S_MUL: if (bus.abort) begin
          state <= S_IDLE;
        end else begin
          if (opb[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          opb   <= opb >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(W-1)) state <= S_FINAL;
        end
        S_DIV: if (bus.abort) begin
          state <= S_IDLE;
        end else begin
          if (!div_trial[W]) acc <= {div_trial[W-1:0], acc[W-2:0], 1'b1};
          else               acc <= {div_shift[W-1:0], acc[W-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W-1)) state <= S_FINAL;
        end
        S_FINAL: if (bus.abort) begin
          state <= S_IDLE;
        end else begin
          state <= S_DONE;
          if (!dbz) {hi_q, lo_q} <= final_res;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.op_ready    = (state == S_IDLE);
  assign bus.busy        = (state != S_IDLE) && (state != S_DONE);
  assign bus.done        = (state == S_DONE);
  assign bus.div_by_zero = (state == S_DONE) && dbz;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule
